// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: CODE_LEN-digit entry, timed unlock, timed lockout after MAX_FAILS rejects.
// Optional idle abandon of partial entries: define CODE_LOCK_ENTRY_TIMEOUT_EN.
module code_lock_ctrl #(
  parameter int DIGIT_W        = 4,
  parameter int CODE_LEN       = 4,
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 500,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int ENTRY_TIMEOUT  = 2000,
  localparam int DIDX_W        = $clog2(CODE_LEN),
  localparam int FC_W          = $clog2(MAX_FAILS + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enter,
  input  logic [DIGIT_W-1:0]           digit,
  input  logic [CODE_LEN*DIGIT_W-1:0]  code,
  input  logic                         relock,
  output logic [1:0]                   state,
  output logic [DIDX_W-1:0]            digit_idx,
  output logic [FC_W-1:0]              fail_count,
  output logic                         locked_led,
  output logic                         unlocked_led,
  output logic                         error_led,
  output logic                         lockout_led
);

  localparam int TMR_MAX0 = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_MAX  = (TMR_MAX0 > ENTRY_TIMEOUT) ? TMR_MAX0 : ENTRY_TIMEOUT;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [DIDX_W-1:0] LAST_IDX = DIDX_W'(CODE_LEN - 1);
  localparam logic [FC_W-1:0]   MAX_F    = FC_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  UNLOCK_T = TMR_W'(UNLOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_T   = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
  localparam logic [TMR_W-1:0]  IDLE_T   = TMR_W'(ENTRY_TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {
    ST_ENTRY    = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [DIDX_W-1:0]   r_digit_idx;
  logic                r_mismatch;
  logic [FC_W-1:0]     r_fail_count;
  logic [TMR_W-1:0]    r_timer;
  logic                r_error_led;
  logic                r_locked_led;
  logic                r_unlocked_led;
  logic                r_lockout_led;

  state_t              w_state_nxt;
  logic [DIDX_W-1:0]   w_idx_nxt;
  logic                w_mis_nxt;
  logic [FC_W-1:0]     w_fail_nxt;
  logic [TMR_W-1:0]    w_timer_nxt;
  logic                w_err_nxt;
  logic                w_digit_mis;
  logic [FC_W-1:0]     w_fail_inc;

  assign w_digit_mis = (digit != code[r_digit_idx*DIGIT_W +: DIGIT_W]);
  assign w_fail_inc  = (r_fail_count >= MAX_F) ? MAX_F : r_fail_count + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_digit_idx;
    w_mis_nxt   = r_mismatch;
    w_fail_nxt  = r_fail_count;
    w_timer_nxt = r_timer;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_ENTRY: begin
        if (enter) begin
          if (r_digit_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            w_mis_nxt = 1'b0;
            if (!(r_mismatch | w_digit_mis)) begin
              w_state_nxt = ST_UNLOCKED;
              w_fail_nxt  = '0;
              w_timer_nxt = UNLOCK_T;
            end else begin
              w_err_nxt  = 1'b1;
              w_fail_nxt = w_fail_inc;
              if (w_fail_inc == MAX_F) begin
                w_state_nxt = ST_LOCKOUT;
                w_timer_nxt = LOCK_T;
              end
            end
          end else begin
            w_idx_nxt = r_digit_idx + 1'b1;
            w_mis_nxt = r_mismatch | w_digit_mis;
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
            w_timer_nxt = IDLE_T;
`endif
          end
        end
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
        // Timer doubles as the idle counter while a partial entry is pending.
        else if (r_digit_idx != '0) begin
          if (r_timer == '0) begin
            w_idx_nxt = '0;
            w_mis_nxt = 1'b0;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end
`endif
      end
      ST_UNLOCKED: begin
        w_idx_nxt = '0;
        w_mis_nxt = 1'b0;
        if (enter || relock || (r_timer == '0)) begin
          w_state_nxt = ST_ENTRY;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_state_nxt = ST_ENTRY;
          w_fail_nxt  = '0;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_ENTRY;
        w_idx_nxt   = '0;
        w_mis_nxt   = 1'b0;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_ENTRY;
      r_digit_idx    <= '0;
      r_mismatch     <= 1'b0;
      r_fail_count   <= '0;
      r_timer        <= '0;
      r_error_led    <= 1'b0;
      r_locked_led   <= 1'b1;
      r_unlocked_led <= 1'b0;
      r_lockout_led  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_digit_idx    <= w_idx_nxt;
      r_mismatch     <= w_mis_nxt;
      r_fail_count   <= w_fail_nxt;
      r_timer        <= w_timer_nxt;
      r_error_led    <= w_err_nxt;
      r_locked_led   <= (w_state_nxt != ST_UNLOCKED);
      r_unlocked_led <= (w_state_nxt == ST_UNLOCKED);
      r_lockout_led  <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign state        = r_state;
  assign digit_idx    = r_digit_idx;
  assign fail_count   = r_fail_count;
  assign error_led    = r_error_led;
  assign locked_led   = r_locked_led;
  assign unlocked_led = r_unlocked_led;
  assign lockout_led  = r_lockout_led;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with secret code 16'h4321 (entry order 1,2,3,4).
module tb_code_lock_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enter;
  logic [3:0]  digit;
  logic [15:0] code;
  logic        relock;
  logic [1:0]  state;
  logic [1:0]  digit_idx;
  logic [1:0]  fail_count;
  logic        locked_led, unlocked_led, error_led, lockout_led;

  int total = 0;
  int bad   = 0;

  code_lock_ctrl #(
    .DIGIT_W(4), .CODE_LEN(4), .MAX_FAILS(3),
    .UNLOCK_CYCLES(10), .LOCKOUT_CYCLES(20), .ENTRY_TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .digit(digit), .code(code),
    .relock(relock), .state(state), .digit_idx(digit_idx), .fail_count(fail_count),
    .locked_led(locked_led), .unlocked_led(unlocked_led),
    .error_led(error_led), .lockout_led(lockout_led)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    enter = 1'b1;
    digit = d;
    tick(1);
    enter = 1'b0;
    digit = 4'h0;
  endtask

  task automatic press_code(input logic [15:0] c);
    press(c[3:0]);
    press(c[7:4]);
    press(c[11:8]);
    press(c[15:12]);
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    tick(1);
    relock = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enter  = 1'b0;
    digit  = 4'h0;
    relock = 1'b0;
    code   = 16'h4321;
    tick(2);
    #1;
    check("rst_state", state, 0);
    check("rst_idx", digit_idx, 0);
    check("rst_fail", fail_count, 0);
    check("rst_locked", locked_led, 1);
    check("rst_unlocked", unlocked_led, 0);
    check("rst_lockout", lockout_led, 0);
    check("rst_error", error_led, 0);
    reset = 1'b0;
    tick(1);

    // correct code, then natural expiry after 10 cycles
    press(4'd1);
    check("ok_idx1", digit_idx, 1);
    press(4'd2);
    press(4'd3);
    check("ok_idx3", digit_idx, 3);
    press(4'd4);
    check("ok_state", state, 1);
    check("ok_unlocked", unlocked_led, 1);
    check("ok_locked", locked_led, 0);
    check("ok_fail", fail_count, 0);
    check("ok_idx0", digit_idx, 0);
    tick(9);
    check("ok_still_open", state, 1);
    tick(1);
    check("ok_expired", state, 0);
    check("ok_expired_locked", locked_led, 1);

    // wrong second digit, no early reject
    press(4'd1);
    press(4'd9);
    check("bad_d2_state", state, 0);
    check("bad_d2_idx", digit_idx, 2);
    press(4'd3);
    check("bad_d3_state", state, 0);
    press(4'd4);
    check("bad_state", state, 0);
    check("bad_err", error_led, 1);
    check("bad_fail", fail_count, 1);
    check("bad_idx", digit_idx, 0);
    tick(1);
    check("bad_err_gone", error_led, 0);

    // relock in ENTRY is ignored
    press(4'd1);
    pulse_relock();
    check("relock_entry_idx", digit_idx, 1);
    check("relock_entry_state", state, 0);
    press(4'd9);
    press(4'd9);
    press(4'd9);
    check("bad2_fail", fail_count, 2);
    check("bad2_err", error_led, 1);

    // third reject -> lockout
    press_code(16'h9999);
    check("lo_state", state, 2);
    check("lo_led", lockout_led, 1);
    check("lo_locked", locked_led, 1);
    check("lo_fail", fail_count, 3);
    check("lo_err", error_led, 1);
    press(4'd1);
    check("lo_enter_idx", digit_idx, 0);
    check("lo_enter_err", error_led, 0);
    pulse_relock();
    check("lo_relock_state", state, 2);
    tick(17);
    check("lo_still", state, 2);
    tick(1);
    check("lo_done_state", state, 0);
    check("lo_done_fail", fail_count, 0);
    check("lo_done_led", lockout_led, 0);

    // early exit by relock on third unlocked cycle
    press_code(16'h4321);
    check("rl_open", state, 1);
    tick(2);
    check("rl_open2", state, 1);
    pulse_relock();
    check("rl_state", state, 0);
    check("rl_idx", digit_idx, 0);

    // early exit by enter; the enter is consumed, not a digit
    press_code(16'h4321);
    tick(2);
    press(4'd1);
    check("en_state", state, 0);
    check("en_idx", digit_idx, 0);
    check("en_err", error_led, 0);
    press(4'd1);
    check("en_next_idx", digit_idx, 1);

    // code changed mid-entry affects only later digits
    code = 16'h4351;
    press(4'd5);
    press(4'd3);
    press(4'd4);
    check("cc_state", state, 1);
    code = 16'h4321;
    enter  = 1'b1;
    relock = 1'b1;
    tick(1);
    enter  = 1'b0;
    relock = 1'b0;
    check("both_state", state, 0);
    check("both_idx", digit_idx, 0);

    // success clears fail counter
    press_code(16'h1111);
    press_code(16'h1111);
    check("clr_fail2", fail_count, 2);
    press_code(16'h4321);
    check("clr_state", state, 1);
    check("clr_fail", fail_count, 0);
    pulse_relock();

    // asynchronous reset mid-entry
    press_code(16'h0000);
    check("ar_fail1", fail_count, 1);
    press(4'd1);
    press(4'd2);
    check("ar_idx_pre", digit_idx, 2);
    #1 reset = 1'b1;
    #1;
    check("ar_idx", digit_idx, 0);
    check("ar_state", state, 0);
    check("ar_fail", fail_count, 0);
    tick(1);
    reset = 1'b0;
    tick(1);

    // partial entry idle behaviour
    press_code(16'h0000);
    press(4'd1);
    press(4'd2);
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
    tick(7);
    check("to_idx_pre", digit_idx, 2);
    tick(1);
    check("to_idx", digit_idx, 0);
    check("to_err", error_led, 0);
    check("to_fail", fail_count, 1);
    press_code(16'h4321);
    check("to_unlock", state, 1);
`else
    tick(50);
    check("nto_idx", digit_idx, 2);
    check("nto_fail", fail_count, 1);
    press(4'd3);
    press(4'd4);
    check("nto_unlock", state, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
Name: code_lock_ctrl

Overview:
- Parametrised keypad code-lock controller, successor to the fixed 3-digit lock FSM.
- Accepts a CODE_LEN-digit sequence of DIGIT_W-bit digits and compares it against a programmable code.
- Unlock auto-expires after a programmable time; MAX_FAILS consecutive failed attempts trigger a timed lockout.
- Sits between the debounced keypad/enter logic and the board LED/status outputs.

Parameters:
- DIGIT_W, 4, bits per digit.
- CODE_LEN, 4, digits per code (>=2).
- MAX_FAILS, 3, consecutive rejected codes that trigger lockout (>=1).
- UNLOCK_CYCLES, 500, clk cycles the lock stays open.
- LOCKOUT_CYCLES, 1000, clk cycles of lockout.
- ENTRY_TIMEOUT, 2000, idle cycles before a partial entry is abandoned (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enter  in  1  single-cycle strobe: digit valid.
- digit  in  DIGIT_W  digit presented with enter.
- code  in  CODE_LEN*DIGIT_W  secret code; digit 0 (first entered) in the LSBs.
- relock  in  1  single-cycle strobe: force relock from UNLOCKED.
- state  out  2  current state encoding.
- digit_idx  out  clog2(CODE_LEN)  index of the next digit expected.
- fail_count  out  clog2(MAX_FAILS+1)  consecutive rejected codes.
- locked_led  out  1  high unless UNLOCKED.
- unlocked_led  out  1  high in UNLOCKED.
- error_led  out  1  one-cycle pulse per rejected code.
- lockout_led  out  1  high in LOCKOUT.

Behaviour:
- States: ENTRY=0, UNLOCKED=1, LOCKOUT=2. Encoding 3 is unused and recovers to ENTRY on the next clk.
- Reset (async): state=ENTRY, digit_idx=0, mismatch flag=0, fail_count=0, timer=0, error_led=0. Therefore locked_led=1 and unlocked_led=lockout_led=0.
- All outputs are registered or decoded from registered state only; nothing depends combinationally on inputs.

ENTRY:
- On each enter, compare digit against code[digit_idx*DIGIT_W +: DIGIT_W], OR the result into a sticky mismatch flag, and increment digit_idx.
- No early reject: all CODE_LEN digits are always collected.
- On the enter of the final digit (digit_idx==CODE_LEN-1), digit_idx wraps to 0 and mismatch clears. Then:
  - All digits matched: next state UNLOCKED, fail_count=0, timer=UNLOCK_CYCLES-1.
  - Otherwise: error_led=1 for exactly the next cycle and fail_count increments.
    - If the new fail_count==MAX_FAILS: next state LOCKOUT, timer=LOCKOUT_CYCLES-1.
    - Otherwise: stay in ENTRY.
- Latency: the state change is visible on the clk edge that samples the final enter.

UNLOCKED:
- Timer decrements each cycle, so the state lasts exactly UNLOCK_CYCLES cycles.
- Leaves to ENTRY when the timer reaches 0, or on relock, or on enter. An enter here is consumed and not treated as a digit.
- digit_idx is held at 0.

LOCKOUT:
- enter and relock are ignored; no digits are recorded and error_led is not pulsed.
- Timer decrements; the state lasts exactly LOCKOUT_CYCLES cycles, then goes to ENTRY with fail_count=0.

General rules:
- relock outside UNLOCKED is ignored.
- Simultaneous enter and relock in UNLOCKED: single transition to ENTRY.
- code is sampled at each enter. Changing it mid-entry affects only the digits still to come.
- fail_count saturates at MAX_FAILS.
- Timer width is clog2(max(UNLOCK_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT)+1).
- Reset asserted mid-entry, mid-unlock or mid-lockout returns immediately to the reset values, including clearing fail_count.

Optional Feature:
Macro CODE_LOCK_ENTRY_TIMEOUT_EN.
- Defined: in ENTRY with digit_idx!=0, an idle counter reloads on every enter. After ENTRY_TIMEOUT consecutive cycles without enter, digit_idx and mismatch clear. This is not a failure: fail_count is unchanged and error_led is not pulsed.
- Undefined: no idle counter; a partial entry persists indefinitely. ENTRY_TIMEOUT is unused.

Test Plan:
Bench parameters: DIGIT_W=4, CODE_LEN=4, MAX_FAILS=3, UNLOCK_CYCLES=10, LOCKOUT_CYCLES=20, code=16'h4321.
- Correct entry: reset, enter digits 1,2,3,4 on separate cycles -> after the 4th edge state=1, unlocked_led=1, locked_led=0, fail_count=0. State returns to 0 exactly 10 cycles later.
- Wrong digit, no early reject: enter 1,9,3,4 -> state stays 0 through all digits, error_led high for one cycle after the 4th, fail_count=1, digit_idx=0.
- Lockout: three wrong codes -> after the 3rd, state=2 and lockout_led=1. Enter strobes during lockout do not change digit_idx. After 20 cycles state=0 and fail_count=0.
- Early exit from UNLOCKED: unlock, then pulse relock on cycle 3 -> state=0 on the next edge. Repeat with an enter strobe instead of relock -> same result, and digit_idx=0.
- Fail counter clears on success, plus reset mid-entry: two wrong codes, then the correct code -> fail_count=0. Separately, enter 1,2 then assert reset -> digit_idx=0 and state=0 immediately (asynchronous).
- With CODE_LOCK_ENTRY_TIMEOUT_EN and ENTRY_TIMEOUT=8: enter 1,2, then idle 8 cycles -> digit_idx=0, error_led stays 0, fail_count unchanged. A following 1,2,3,4 unlocks.
